// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the fetch front end.
package pc_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One queued fetch result: the PC it was fetched from and the word returned
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Force a byte address onto a word boundary
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_queue.sv
// Small FIFO of {pc, inst} pairs between fetch and decode.
// Flush wins over push; pop and flush together are legal.
module pc_fetch_unit_queue
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    fetch_entry_t       mem [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               pop_ok;
    logic               push_ok;

    // Circular pointer advance for non power-of-two depths
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(QDEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Qualify requests: never pop empty, never overrun full
    always_comb begin
        pop_ok  = pop && (count_q != '0);
        push_ok = push && !flush && ((count_q != CNT_W'(QDEPTH)) || pop_ok);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register, one-outstanding instruction memory requester and
// decode-facing instruction queue with redirect/flush handling.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    fetch_state_e       state_q;
    fetch_state_e       state_n;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    pc_n;
    logic [XLEN-1:0]    req_pc_q;
    logic [XLEN-1:0]    req_pc_n;
    logic               req_q;
    logic               req_n;
    logic               fire;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_n;
    fetch_entry_t       push_data;
    fetch_entry_t       head;

    // Request accepted by memory this cycle
    assign fire = (state_q == FS_REQ) && req_q && imem_ack;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_REQ;
        end else begin
            state_q <= state_n;
        end
    end

    // FSM next state; a redirect turns any live request into one to be dropped
    always_comb begin
        state_n = state_q;
        case (state_q)
            FS_REQ: begin
                if (fire) begin
                    state_n = redirect_valid ? FS_DROP : FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (imem_rvalid) begin
                    state_n = FS_REQ;
                end else if (redirect_valid) begin
                    state_n = FS_DROP;
                end
            end
            FS_DROP: begin
                if (imem_rvalid) begin
                    state_n = FS_REQ;
                end
            end
            default: state_n = FS_REQ;
        endcase
    end

    // Next values for pc, request tracking, queue control and the request line
    always_comb begin
        pc_n      = pc_q;
        req_pc_n  = req_pc_q;
        push      = 1'b0;
        pop       = inst_valid && inst_ready;
        push_data = '0;
        count_n   = count;

        if (redirect_valid) begin
            pc_n = word_align(redirect_pc);
        end else if (fire) begin
            pc_n = pc_q + PC_INC;
        end

        if (fire) begin
            req_pc_n = pc_q;
        end

        push           = (state_q == FS_WAIT) && imem_rvalid && !redirect_valid;
        push_data.pc   = req_pc_q;
        push_data.inst = imem_rdata;

        if (redirect_valid) begin
            count_n = '0;
        end else if (push && !pop) begin
            count_n = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_n = count - CNT_W'(1);
        end

        req_n = (state_n == FS_REQ) && (count_n < CNT_W'(QDEPTH));
    end

    // PC, request PC and registered request line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            req_q    <= 1'b0;
        end else begin
            pc_q     <= pc_n;
            req_pc_q <= req_pc_n;
            req_q    <= req_n;
        end
    end

    pc_fetch_unit_queue #(
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    // pc only moves on accept or redirect, so it doubles as the held request address
    assign pc         = pc_q;
    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign inst_valid = (count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

endmodule
